// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the core's single data-memory port: CPU MEM stage vs external master.
// CPU wins by default; starvation and burst counters hand the port to EXT for bounded bursts.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int MASK_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [MASK_W-1:0] cpu_wmask,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [MASK_W-1:0] ext_wmask,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_prio_ext
);

    // Handshake: a requester holds req (and stable fields) until its gnt is seen
    // high in the same cycle; the access is issued on the memory port in that cycle.

    localparam int WAIT_W  = $clog2(STARVE_LIMIT) + 1;
    localparam int BURST_W = $clog2(MAX_BURST) + 1;
    localparam logic [WAIT_W-1:0]  WAIT_TERM  = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BURST_W-1:0] BURST_TERM = BURST_W'(MAX_BURST - 1);

    typedef enum logic {
        P_CPU = 1'b0,
        P_EXT = 1'b1
    } prio_t;

    prio_t               prio_q, prio_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [MEM_LAT-1:0]  rv_vld_q;
    logic [MEM_LAT-1:0]  rv_own_q;   // 1 = read belongs to EXT
    logic                rd_issue;

    // Grants are forced low in reset so every output reads 0 while nrst=0.
    always_comb begin
        cpu_gnt   = nrst & cpu_req & ((prio_q == P_CPU) | ~ext_req);
        ext_gnt   = nrst & ext_req & ((prio_q == P_EXT) | ~cpu_req);
        cpu_stall = nrst & cpu_req & ~cpu_gnt;
        rd_issue  = (cpu_gnt & ~cpu_we) | (ext_gnt & ~ext_we);
    end

    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wr_en = cpu_we;
            mem_wdata = cpu_wdata;
            mem_wmask = cpu_wmask;
        end else if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wr_en = ext_we;
            mem_wdata = ext_wdata;
            mem_wmask = ext_wmask;
        end
    end

    always_comb begin
        prio_d  = prio_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        case (prio_q)
            P_CPU: begin
                burst_d = '0;
                if (ext_req && !ext_gnt) begin
                    if (wait_q == WAIT_TERM) begin
                        prio_d = P_EXT;
                        wait_d = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            P_EXT: begin
                wait_d = '0;
                if (!ext_req) begin
                    prio_d  = P_CPU;
                    burst_d = '0;
                end else if (ext_gnt) begin
                    if (burst_q == BURST_TERM) begin
                        prio_d  = P_CPU;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end
            end
            default: begin
                prio_d  = P_CPU;
                wait_d  = '0;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            prio_q   <= P_CPU;
            wait_q   <= '0;
            burst_q  <= '0;
            rv_vld_q <= '0;
            rv_own_q <= '0;
        end else begin
            prio_q      <= prio_d;
            wait_q      <= wait_d;
            burst_q     <= burst_d;
            rv_vld_q[0] <= rd_issue;
            rv_own_q[0] <= ext_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                rv_vld_q[i] <= rv_vld_q[i-1];
                rv_own_q[i] <= rv_own_q[i-1];
            end
        end
    end

    // Read data is the raw memory bus; rvalid decides whose it is.
    always_comb begin
        cpu_rvalid   = nrst & rv_vld_q[MEM_LAT-1] & ~rv_own_q[MEM_LAT-1];
        ext_rvalid   = nrst & rv_vld_q[MEM_LAT-1] &  rv_own_q[MEM_LAT-1];
        cpu_rdata    = nrst ? mem_rdata : '0;
        ext_rdata    = nrst ? mem_rdata : '0;
        dbg_prio_ext = nrst & (prio_q == P_EXT);
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (read latency 1 and 3) share stimulus
// and are checked against a transaction-level model of priority and read returns.
module tb_dmem_port_arbiter;

    logic        clk, nrst;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, ext_addr;
    logic [63:0] cpu_wdata, ext_wdata, mem_rdata;
    logic [7:0]  cpu_wmask, ext_wmask;

    logic        a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_cpu_rvalid, a_ext_rvalid, a_mem_wr_en, a_dbg;
    logic [63:0] a_cpu_rdata, a_ext_rdata, a_mem_wdata;
    logic [31:0] a_mem_addr;
    logic [7:0]  a_mem_wmask;
    logic        b_cpu_gnt, b_ext_gnt, b_cpu_stall, b_cpu_rvalid, b_ext_rvalid, b_mem_wr_en, b_dbg;
    logic [63:0] b_cpu_rdata, b_ext_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_wmask;

    dmem_port_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_gnt(a_cpu_gnt), .cpu_stall(a_cpu_stall), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_wmask(ext_wmask),
        .ext_gnt(a_ext_gnt), .ext_rvalid(a_ext_rvalid), .ext_rdata(a_ext_rdata),
        .mem_addr(a_mem_addr), .mem_wr_en(a_mem_wr_en), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_rdata(mem_rdata), .dbg_prio_ext(a_dbg)
    );

    dmem_port_arbiter #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_gnt(b_cpu_gnt), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_wmask(ext_wmask),
        .ext_gnt(b_ext_gnt), .ext_rvalid(b_ext_rvalid), .ext_rdata(b_ext_rdata),
        .mem_addr(b_mem_addr), .mem_wr_en(b_mem_wr_en), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_rdata(mem_rdata), .dbg_prio_ext(b_dbg)
    );

    // Clock and counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: priority owner, EXT blocked streak, EXT burst length,
    // and queues of outstanding reads (due cycle, owner) per latency.
    bit          m_prio_ext = 0;
    int          m_blocked  = 0;
    int          m_burst    = 0;
    int          due1_q[$];
    bit          own1_q[$];
    int          due3_q[$];
    bit          own3_q[$];

    logic        exp_cpu_gnt, exp_ext_gnt, exp_stall, exp_mem_wr, exp_prio;
    logic        exp_cpu_rv1, exp_ext_rv1, exp_cpu_rv3, exp_ext_rv3;
    logic [31:0] exp_mem_addr;
    logic [63:0] exp_mem_wdata, exp_rdata;
    logic [7:0]  exp_mem_wmask;

    function automatic void eval_model();
        exp_cpu_gnt   = nrst && cpu_req && (!m_prio_ext || !ext_req);
        exp_ext_gnt   = nrst && ext_req && (m_prio_ext || !cpu_req);
        exp_stall     = nrst && cpu_req && !exp_cpu_gnt;
        exp_prio      = nrst && m_prio_ext;
        exp_mem_wr    = exp_cpu_gnt ? cpu_we    : exp_ext_gnt ? ext_we    : 1'b0;
        exp_mem_addr  = exp_cpu_gnt ? cpu_addr  : exp_ext_gnt ? ext_addr  : 32'h0;
        exp_mem_wdata = exp_cpu_gnt ? cpu_wdata : exp_ext_gnt ? ext_wdata : 64'h0;
        exp_mem_wmask = exp_cpu_gnt ? cpu_wmask : exp_ext_gnt ? ext_wmask : 8'h0;
        exp_rdata     = nrst ? mem_rdata : 64'h0;
        exp_cpu_rv1   = nrst && due1_q.size() > 0 && due1_q[0] == cyc && !own1_q[0];
        exp_ext_rv1   = nrst && due1_q.size() > 0 && due1_q[0] == cyc &&  own1_q[0];
        exp_cpu_rv3   = nrst && due3_q.size() > 0 && due3_q[0] == cyc && !own3_q[0];
        exp_ext_rv3   = nrst && due3_q.size() > 0 && due3_q[0] == cyc &&  own3_q[0];
    endfunction

    // Advance one clock and update the model with the inputs of the finished cycle.
    task automatic tick();
        eval_model();
        @(posedge clk);
        if (!nrst) begin
            m_prio_ext = 0;
            m_blocked  = 0;
            m_burst    = 0;
            due1_q.delete(); own1_q.delete();
            due3_q.delete(); own3_q.delete();
        end else begin
            if (due1_q.size() > 0 && due1_q[0] == cyc) begin void'(due1_q.pop_front()); void'(own1_q.pop_front()); end
            if (due3_q.size() > 0 && due3_q[0] == cyc) begin void'(due3_q.pop_front()); void'(own3_q.pop_front()); end
            if ((exp_cpu_gnt && !cpu_we) || (exp_ext_gnt && !ext_we)) begin
                due1_q.push_back(cyc + 1); own1_q.push_back(exp_ext_gnt);
                due3_q.push_back(cyc + 3); own3_q.push_back(exp_ext_gnt);
            end
            if (!m_prio_ext) begin
                // EXT gets priority once it has been refused STARVE_LIMIT cycles in a row
                if (ext_req && !exp_ext_gnt) begin
                    m_blocked++;
                    if (m_blocked == 4) begin m_prio_ext = 1; m_blocked = 0; m_burst = 0; end
                end else begin
                    m_blocked = 0;
                end
            end else begin
                if (!ext_req) begin
                    m_prio_ext = 0; m_burst = 0;
                end else if (exp_ext_gnt) begin
                    m_burst++;
                    if (m_burst == 4) begin m_prio_ext = 0; m_burst = 0; end
                end
            end
        end
        cyc++;
        #1;
    endtask

    // Driver tasks
    task automatic idle();
        cpu_req = 0; ext_req = 0; cpu_we = 0; ext_we = 0;
        cpu_addr = '0; ext_addr = '0; cpu_wdata = '0; ext_wdata = '0; cpu_wmask = '0; ext_wmask = '0;
    endtask

    task automatic new_cpu();
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom;
        cpu_wdata = {$urandom, $urandom}; cpu_wmask = 8'($urandom_range(0, 255));
    endtask

    task automatic new_ext();
        ext_we = 1'($urandom_range(0, 1)); ext_addr = $urandom;
        ext_wdata = {$urandom, $urandom}; ext_wmask = 8'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        logic [238:0] all_a, all_b;
        nrst = 0; cpu_req = 1; ext_req = 1; new_cpu(); new_ext();
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        eval_model();
        @(negedge clk);
        all_a = {a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_cpu_rvalid, a_ext_rvalid, a_mem_wr_en, a_dbg,
                 a_mem_addr, a_mem_wdata, a_mem_wmask, a_cpu_rdata, a_ext_rdata};
        all_b = {b_cpu_gnt, b_ext_gnt, b_cpu_stall, b_cpu_rvalid, b_ext_rvalid, b_mem_wr_en, b_dbg,
                 b_mem_addr, b_mem_wdata, b_mem_wmask, b_cpu_rdata, b_ext_rdata};
        n_checks++; if (all_a !== '0) begin n_errors++; $display("FAIL reset_outputs_lat1 got %h exp 0", all_a); end
        n_checks++; if (all_b !== '0) begin n_errors++; $display("FAIL reset_outputs_lat3 got %h exp 0", all_b); end
        tick();
        nrst = 1;
        eval_model();
        @(negedge clk);
        n_checks++; if ({a_cpu_gnt, a_ext_gnt, a_cpu_stall} !== 3'b100) begin n_errors++;
            $display("FAIL reset_first_grant_lat1 got %b exp 100", {a_cpu_gnt, a_ext_gnt, a_cpu_stall}); end
        n_checks++; if ({b_cpu_gnt, b_ext_gnt, b_cpu_stall} !== 3'b100) begin n_errors++;
            $display("FAIL reset_first_grant_lat3 got %b exp 100", {b_cpu_gnt, b_ext_gnt, b_cpu_stall}); end
        tick();
        idle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_cpu_read();
        idle(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        eval_model();
        @(negedge clk);
        n_checks++; if ({a_cpu_gnt, a_mem_wr_en, a_mem_addr} !== {2'b10, 32'h100}) begin n_errors++;
            $display("FAIL cpu_read_issue got gnt=%b we=%b addr=%h exp 1 0 100", a_cpu_gnt, a_mem_wr_en, a_mem_addr); end
        tick();
        cpu_req = 0; mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        n_checks++; if ({a_cpu_rvalid, a_ext_rvalid, a_cpu_rdata} !== {2'b10, mem_rdata}) begin n_errors++;
            $display("FAIL cpu_read_return_lat1 got rv=%b%b data=%h exp 10 %h", a_cpu_rvalid, a_ext_rvalid, a_cpu_rdata, mem_rdata); end
        tick(); tick();
        mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        n_checks++; if ({b_cpu_rvalid, b_ext_rvalid, b_cpu_rdata} !== {2'b10, mem_rdata}) begin n_errors++;
            $display("FAIL cpu_read_return_lat3 got rv=%b%b data=%h exp 10 %h", b_cpu_rvalid, b_ext_rvalid, b_cpu_rdata, mem_rdata); end
        tick();
    endtask

    task automatic test_ext_write();
        idle(); ext_req = 1; ext_we = 1; ext_addr = 32'h200; ext_wdata = 64'hDEAD_BEEF; ext_wmask = 8'hFF;
        eval_model();
        @(negedge clk);
        n_checks++; if ({a_ext_gnt, a_cpu_gnt, a_mem_wr_en, a_mem_addr, a_mem_wdata, a_mem_wmask} !==
                        {3'b101, 32'h200, 64'hDEAD_BEEF, 8'hFF}) begin n_errors++;
            $display("FAIL ext_write_issue got gnt=%b%b we=%b addr=%h data=%h mask=%h", a_ext_gnt, a_cpu_gnt,
                     a_mem_wr_en, a_mem_addr, a_mem_wdata, a_mem_wmask); end
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if ({a_cpu_rvalid, a_ext_rvalid, b_cpu_rvalid, b_ext_rvalid} !== 4'b0) begin n_errors++;
                $display("FAIL ext_write_no_rvalid k=%0d got %b exp 0000", k,
                         {a_cpu_rvalid, a_ext_rvalid, b_cpu_rvalid, b_ext_rvalid}); end
            tick();
        end
    endtask

    task automatic test_starvation();
        logic exp_c;
        idle(); cpu_req = 1; cpu_addr = 32'h300; ext_req = 1; ext_we = 1; ext_addr = 32'h400;
        for (int k = 0; k < 20; k++) begin
            exp_c = (k % 8) < 4;
            eval_model();
            @(negedge clk);
            n_checks++; if ({a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_mem_addr} !== {exp_c, !exp_c, !exp_c, exp_c ? 32'h300 : 32'h400}) begin
                n_errors++;
                $display("FAIL starvation k=%0d got gnt=%b%b stall=%b addr=%h exp cpu_gnt=%b", k, a_cpu_gnt,
                         a_ext_gnt, a_cpu_stall, a_mem_addr, exp_c); end
            tick();
        end
        idle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        int m1, m3;
        logic [1:0] e1, e3;
        for (int j = 0; j < 12; j++) begin
            idle();
            if (j < 8) begin
                if (j % 2 == 0) begin cpu_req = 1; cpu_addr = 32'(j); end
                else            begin ext_req = 1; ext_addr = 32'(j); end
            end
            mem_rdata = {$urandom, $urandom};
            m1 = j - 1; m3 = j - 3;
            e1 = (m1 >= 0 && m1 < 8) ? ((m1 % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            e3 = (m3 >= 0 && m3 < 8) ? ((m3 % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            eval_model();
            @(negedge clk);
            if (j < 8) begin
                n_checks++; if ({a_cpu_gnt, a_ext_gnt} !== ((j % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++;
                    $display("FAIL b2b_grant j=%0d got %b%b", j, a_cpu_gnt, a_ext_gnt); end
            end
            n_checks++; if ({a_cpu_rvalid, a_ext_rvalid} !== e1) begin n_errors++;
                $display("FAIL b2b_tag_lat1 j=%0d got %b%b exp %b", j, a_cpu_rvalid, a_ext_rvalid, e1); end
            n_checks++; if ({b_cpu_rvalid, b_ext_rvalid} !== e3) begin n_errors++;
                $display("FAIL b2b_tag_lat3 j=%0d got %b%b exp %b", j, b_cpu_rvalid, b_ext_rvalid, e3); end
            if (e3 != 2'b00) begin
                n_checks++; if ((e3[1] ? b_cpu_rdata : b_ext_rdata) !== mem_rdata) begin n_errors++;
                    $display("FAIL b2b_rdata_lat3 j=%0d got %h exp %h", j, e3[1] ? b_cpu_rdata : b_ext_rdata, mem_rdata); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            if (cpu_req && !exp_cpu_gnt) begin
                if ($urandom_range(0, 9) == 0) cpu_req = 0;
            end else begin
                cpu_req = ($urandom_range(0, 9) < 7); new_cpu();
            end
            if (ext_req && !exp_ext_gnt) begin
                if ($urandom_range(0, 9) == 0) ext_req = 0;
            end else begin
                ext_req = ($urandom_range(0, 9) < 6); new_ext();
            end
            mem_rdata = {$urandom, $urandom};
            eval_model();
            @(negedge clk);
            n_checks++; if ({a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_mem_wr_en, a_dbg, a_cpu_rvalid, a_ext_rvalid} !==
                            {exp_cpu_gnt, exp_ext_gnt, exp_stall, exp_mem_wr, exp_prio, exp_cpu_rv1, exp_ext_rv1}) begin
                n_errors++; $display("FAIL rnd_ctl_lat1 cyc=%0d got %b exp %b", cyc,
                    {a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_mem_wr_en, a_dbg, a_cpu_rvalid, a_ext_rvalid},
                    {exp_cpu_gnt, exp_ext_gnt, exp_stall, exp_mem_wr, exp_prio, exp_cpu_rv1, exp_ext_rv1}); end
            n_checks++; if ({b_cpu_gnt, b_ext_gnt, b_cpu_stall, b_mem_wr_en, b_dbg, b_cpu_rvalid, b_ext_rvalid} !==
                            {exp_cpu_gnt, exp_ext_gnt, exp_stall, exp_mem_wr, exp_prio, exp_cpu_rv3, exp_ext_rv3}) begin
                n_errors++; $display("FAIL rnd_ctl_lat3 cyc=%0d got %b exp %b", cyc,
                    {b_cpu_gnt, b_ext_gnt, b_cpu_stall, b_mem_wr_en, b_dbg, b_cpu_rvalid, b_ext_rvalid},
                    {exp_cpu_gnt, exp_ext_gnt, exp_stall, exp_mem_wr, exp_prio, exp_cpu_rv3, exp_ext_rv3}); end
            n_checks++; if ({a_mem_addr, a_mem_wdata, a_mem_wmask} !== {exp_mem_addr, exp_mem_wdata, exp_mem_wmask}) begin
                n_errors++; $display("FAIL rnd_bus_lat1 cyc=%0d got %h exp %h", cyc, {a_mem_addr, a_mem_wdata, a_mem_wmask},
                    {exp_mem_addr, exp_mem_wdata, exp_mem_wmask}); end
            n_checks++; if ({b_mem_addr, b_mem_wdata, b_mem_wmask} !== {exp_mem_addr, exp_mem_wdata, exp_mem_wmask}) begin
                n_errors++; $display("FAIL rnd_bus_lat3 cyc=%0d got %h exp %h", cyc, {b_mem_addr, b_mem_wdata, b_mem_wmask},
                    {exp_mem_addr, exp_mem_wdata, exp_mem_wmask}); end
            n_checks++; if ({a_cpu_rdata, a_ext_rdata, b_cpu_rdata, b_ext_rdata} !== {4{exp_rdata}}) begin
                n_errors++; $display("FAIL rnd_rdata cyc=%0d got %h %h %h %h exp %h", cyc, a_cpu_rdata, a_ext_rdata,
                    b_cpu_rdata, b_ext_rdata, exp_rdata); end
            tick();
        end
        idle();
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_reset_midflight();
        idle(); cpu_req = 1; ext_req = 1; cpu_addr = 32'h500; ext_addr = 32'h600;
        for (int k = 0; k < 5; k++) begin
            eval_model();
            @(negedge clk);
            if (k == 4) begin
                n_checks++; if ({a_cpu_gnt, a_ext_gnt, a_cpu_stall} !== 3'b011) begin n_errors++;
                    $display("FAIL midflight_ext_turn got %b exp 011", {a_cpu_gnt, a_ext_gnt, a_cpu_stall}); end
            end
            tick();
        end
        n_checks++; if ({a_dbg, b_dbg} !== 2'b11) begin n_errors++;
            $display("FAIL midflight_prio_ext got %b exp 11", {a_dbg, b_dbg}); end
        nrst = 0;
        eval_model();
        @(negedge clk);
        n_checks++; if ({a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_cpu_rvalid, a_ext_rvalid, a_dbg,
                         b_cpu_rvalid, b_ext_rvalid, b_dbg} !== 9'b0) begin n_errors++;
            $display("FAIL midflight_in_reset got %b exp 0", {a_cpu_gnt, a_ext_gnt, a_cpu_stall, a_cpu_rvalid,
                     a_ext_rvalid, a_dbg, b_cpu_rvalid, b_ext_rvalid, b_dbg}); end
        tick();
        nrst = 1; cpu_we = 1; ext_we = 1;
        for (int k = 0; k < 4; k++) begin
            eval_model();
            @(negedge clk);
            if (k == 0) begin
                n_checks++; if ({a_cpu_gnt, a_ext_gnt, a_dbg, b_dbg} !== 4'b1000) begin n_errors++;
                    $display("FAIL midflight_prio_cpu got %b exp 1000", {a_cpu_gnt, a_ext_gnt, a_dbg, b_dbg}); end
            end
            n_checks++; if ({a_cpu_rvalid, a_ext_rvalid, b_cpu_rvalid, b_ext_rvalid} !== 4'b0) begin n_errors++;
                $display("FAIL midflight_dropped k=%0d got %b exp 0000", k,
                         {a_cpu_rvalid, a_ext_rvalid, b_cpu_rvalid, b_ext_rvalid}); end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        nrst = 0; mem_rdata = '0;
        idle();
        test_reset();
        test_cpu_read();
        test_ext_write();
        test_starvation();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
